// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_arbiter
// Purpose  : Round-robin sharing of one start/done shift-add multiplier among
//            NREQ requesters. Optional WAIT timeout via MUL_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mul_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_mlr,
    input  logic [NREQ*DW-1:0]   req_mld,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_prod,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 mul_start,
    output logic [DW-1:0]        mul_mlr,
    output logic [DW-1:0]        mul_mld,
    input  logic                 mul_done,
    input  logic [DW-1:0]        mul_prod
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] c_last = PW'(NREQ - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_wait  = 2'd2;
    localparam logic [1:0] c_resp  = 2'd3;

    if (NREQ < 2 || NREQ > 8 || DW < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("mul_share_arbiter: parameter out of range");
    end

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_winner;
    logic [PW-1:0]   w_winner;
    logic            w_found;
    int              w_idx;
    logic [DW-1:0]   r_mlr;
    logic [DW-1:0]   r_mld;
    logic [DW-1:0]   r_prod;
    logic [NREQ-1:0] w_onehot;
    logic            w_timeout;

    // Rotating priority search starting at the pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        w_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_idle;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_found) w_next_state = c_issue;
            c_issue: w_next_state = c_wait;
            c_wait:  if (mul_done || w_timeout) w_next_state = c_resp;
            c_resp:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_winner;

    always_comb begin
        gnt       = '0;
        rsp_valid = '0;
        mul_start = 1'b0;
        busy      = (r_state != c_idle);
        case (r_state)
            c_issue: begin
                gnt       = w_onehot;
                mul_start = 1'b1;
            end
            c_resp:  rsp_valid = w_onehot;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_winner <= '0;
            r_mlr    <= '0;
            r_mld    <= '0;
            r_prod   <= '0;
        end else begin
            case (r_state)
                c_idle: if (w_found) begin
                    r_winner <= w_winner;
                    r_mlr    <= req_mlr[w_winner*DW +: DW];
                    r_mld    <= req_mld[w_winner*DW +: DW];
                end
                // A timeout returns zero rather than whatever the multiplier shows.
                c_wait: if (mul_done || w_timeout) r_prod <= w_timeout ? '0 : mul_prod;
                c_resp: r_rr_ptr <= (r_winner == c_last) ? '0 : r_winner + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_rsp_err;

    assign w_timeout = (r_state == c_wait) && !mul_done && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == c_issue)     r_cnt <= '0;
            else if (r_state == c_wait) r_cnt <= r_cnt + 1'b1;
            if (r_state == c_wait && (mul_done || w_timeout)) r_rsp_err <= w_timeout;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign rsp_prod = r_prod;
    assign mul_mlr  = r_mlr;
    assign mul_mld  = r_mld;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_share_arbiter
// Purpose  : Directed self-checking bench; the bench plays the multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*DW-1:0] req_mlr = '0;
    logic [NREQ*DW-1:0] req_mld = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_prod;
    logic              rsp_err;
    logic              busy;
    logic              mul_start;
    logic [DW-1:0]     mul_mlr;
    logic [DW-1:0]     mul_mld;
    logic              mul_done = 1'b0;
    logic [DW-1:0]     mul_prod = '0;

    int n_checks = 0;
    int n_errors = 0;

    mul_share_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .req_mlr(req_mlr), .req_mld(req_mld),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_prod(rsp_prod), .rsp_err(rsp_err),
        .busy(busy), .mul_start(mul_start), .mul_mlr(mul_mlr), .mul_mld(mul_mld),
        .mul_done(mul_done), .mul_prod(mul_prod)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; mul_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns the first nonzero gnt seen at a falling edge, or 0 after 20 cycles.
    task automatic wait_gnt(output logic [NREQ-1:0] g);
        g = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                g = gnt;
                break;
            end
        end
    endtask

    // Called at the ISSUE falling edge: returns done after `lag` cycles, then samples RESP.
    task automatic finish_mul(input logic [DW-1:0] p, input int lag,
                              output logic [NREQ-1:0] rv, output logic [DW-1:0] rp,
                              output logic re);
        repeat (lag) @(negedge clk);
        mul_done = 1'b1; mul_prod = p;
        @(negedge clk);
        mul_done = 1'b0; mul_prod = '0;
        rv = rsp_valid; rp = rsp_prod; re = rsp_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({gnt, rsp_valid, rsp_prod, rsp_err, busy, mul_start, mul_mlr, mul_mld} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got gnt=%b rv=%b prod=%h err=%b busy=%b start=%b mlr=%h mld=%h, expected all 0",
                     gnt, rsp_valid, rsp_prod, rsp_err, busy, mul_start, mul_mlr, mul_mld);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [NREQ-1:0] rv; logic [DW-1:0] rp; logic re;
        @(negedge clk);
        req = 4'b0001; req_mlr[0 +: DW] = 16'd3; req_mld[0 +: DW] = 16'd5;
        @(negedge clk);
        req = '0;
        n_checks++;
        if ({gnt, mul_start, busy} !== {4'b0001, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL single_issue: got gnt=%b start=%b busy=%b, expected 0001 1 1", gnt, mul_start, busy);
        end
        n_checks++;
        if ({mul_mlr, mul_mld} !== {16'd3, 16'd5}) begin
            n_errors++;
            $display("FAIL single_operands: got %h/%h, expected 0003/0005", mul_mlr, mul_mld);
        end
        @(negedge clk);
        n_checks++;
        if ({gnt, mul_start} !== 5'b0) begin
            n_errors++;
            $display("FAIL single_pulse_width: got gnt=%b start=%b, expected 0000 0", gnt, mul_start);
        end
        finish_mul(16'd15, 0, rv, rp, re);
        n_checks++;
        if ({rv, rp, re} !== {4'b0001, 16'd15, 1'b0}) begin
            n_errors++;
            $display("FAIL single_resp: got rv=%b prod=%h err=%b, expected 0001 000f 0", rv, rp, re);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, rsp_valid, rsp_prod} !== {1'b0, 4'b0000, 16'd15}) begin
            n_errors++;
            $display("FAIL single_idle: got busy=%b rv=%b prod=%h, expected 0 0000 000f", busy, rsp_valid, rsp_prod);
        end
    endtask

    task automatic test_round_robin_all();
        logic [NREQ-1:0] g, rv; logic [DW-1:0] rp; logic re;
        logic [DW-1:0] prods [5] = '{16'd0, 16'd14, 16'd28, 16'd42, 16'd0};
        logic [NREQ-1:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [DW-1:0] mlrs [5] = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd0};
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_mlr[i*DW +: DW] = DW'(i * 2);
            req_mld[i*DW +: DW] = 16'd7;
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g);
            n_checks++;
            if ({g, mul_mlr, mul_mld} !== {order[k], mlrs[k], 16'd7}) begin
                n_errors++;
                $display("FAIL rr_all_grant%0d: got gnt=%b mlr=%h mld=%h, expected %b %h 0007",
                         k, g, mul_mlr, mul_mld, order[k], mlrs[k]);
            end
            finish_mul(prods[k], 1, rv, rp, re);
            n_checks++;
            if ({rv, rp} !== {order[k], prods[k]}) begin
                n_errors++;
                $display("FAIL rr_all_resp%0d: got rv=%b prod=%h, expected %b %h", k, rv, rp, order[k], prods[k]);
            end
        end
        req = '0;
    endtask

    task automatic test_pointer_skip();
        logic [NREQ-1:0] g, rv; logic [DW-1:0] rp; logic re;
        logic [NREQ-1:0] order [3] = '{4'b1000, 4'b0001, 4'b0010};
        do_reset();
        req = 4'b0010;
        wait_gnt(g);
        req = '0;
        finish_mul(16'd1, 1, rv, rp, re);
        req = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(g);
            req = req & ~g;
            n_checks++;
            if (g !== order[k]) begin
                n_errors++;
                $display("FAIL ptr_skip_grant%0d: got %b, expected %b", k, g, order[k]);
            end
            finish_mul(16'd2, 1, rv, rp, re);
        end
    endtask

    task automatic test_signed_and_stray_done();
        logic [NREQ-1:0] g, rv; logic [DW-1:0] rp; logic re;
        do_reset();
        mul_done = 1'b1; mul_prod = 16'h1234;
        @(negedge clk);
        mul_done = 1'b0; mul_prod = '0;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, busy, rsp_prod} !== {4'b0000, 1'b0, 16'h0000}) begin
            n_errors++;
            $display("FAIL stray_done: got rv=%b busy=%b prod=%h, expected 0000 0 0000", rsp_valid, busy, rsp_prod);
        end
        req_mlr[2*DW +: DW] = 16'hFFFC; req_mld[2*DW +: DW] = 16'd6;
        req = 4'b0100;
        wait_gnt(g);
        req = '0;
        n_checks++;
        if ({g, mul_mlr, mul_mld} !== {4'b0100, 16'hFFFC, 16'h0006}) begin
            n_errors++;
            $display("FAIL signed_issue: got gnt=%b mlr=%h mld=%h, expected 0100 fffc 0006", g, mul_mlr, mul_mld);
        end
        finish_mul(16'hFFE8, 2, rv, rp, re);
        n_checks++;
        if ({rv, rp} !== {4'b0100, 16'hFFE8}) begin
            n_errors++;
            $display("FAIL signed_resp: got rv=%b prod=%h, expected 0100 ffe8", rv, rp);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [NREQ-1:0] g, rv; logic [DW-1:0] rp; logic re;
        logic [NREQ-1:0] seen;
        do_reset();
        req_mlr[0 +: DW] = 16'd9; req_mld[0 +: DW] = 16'd9;
        req = 4'b0001;
        wait_gnt(g);
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({gnt, rsp_valid, busy, mul_start, mul_mlr, mul_mld, rsp_prod} !== '0) begin
            n_errors++;
            $display("FAIL rst_mid_wait: got gnt=%b rv=%b busy=%b start=%b mlr=%h mld=%h prod=%h, expected all 0",
                     gnt, rsp_valid, busy, mul_start, mul_mlr, mul_mld, rsp_prod);
        end
        @(negedge clk);
        rst = 1'b0;
        mul_done = 1'b1; mul_prod = 16'd81;
        seen = '0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        mul_done = 1'b0; mul_prod = '0;
        n_checks++;
        if (seen !== 4'b0000) begin
            n_errors++;
            $display("FAIL rst_no_resp: got rv=%b, expected 0000", seen);
        end
        req_mlr[2*DW +: DW] = 16'd2; req_mld[2*DW +: DW] = 16'd3;
        req = 4'b0100;
        wait_gnt(g);
        req = '0;
        finish_mul(16'd6, 1, rv, rp, re);
        n_checks++;
        if ({g, rv, rp, re} !== {4'b0100, 4'b0100, 16'd6, 1'b0}) begin
            n_errors++;
            $display("FAIL rst_recover: got gnt=%b rv=%b prod=%h err=%b, expected 0100 0100 0006 0", g, rv, rp, re);
        end
    endtask

`ifdef MUL_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [NREQ-1:0] g; logic [NREQ-1:0] seen;
        int n;
        do_reset();
        req_mlr[0 +: DW] = 16'd4; req_mld[0 +: DW] = 16'd4;
        req = 4'b0001;
        wait_gnt(g);
        req = '0;
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                n = i;
                break;
            end
        end
        // 64 WAIT cycles follow ISSUE, so RESP is the 65th cycle after it.
        n_checks++;
        if (n !== 65) begin
            n_errors++;
            $display("FAIL timeout_latency: got %0d cycles, expected 65", n);
        end
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_prod} !== {4'b0001, 1'b1, 16'h0000}) begin
            n_errors++;
            $display("FAIL timeout_resp: got rv=%b err=%b prod=%h, expected 0001 1 0000", rsp_valid, rsp_err, rsp_prod);
        end
        mul_done = 1'b1; mul_prod = 16'd16;
        seen = '0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        mul_done = 1'b0;
        n_checks++;
        if ({seen, busy} !== 5'b0) begin
            n_errors++;
            $display("FAIL timeout_late_done: got rv=%b busy=%b, expected 0000 0", seen, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin_all();
        test_pointer_skip();
        test_signed_and_stray_done();
        test_reset_mid_wait();
`ifdef MUL_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one shift-add multiplier (16-bit signed, start/done handshake) among NREQ requesters.
- Used by the ELM hidden-layer compute: each neuron lane requests products, and this block serialises them onto the single multiplier instance.
- Per transaction: latches the winner's operands, pulses the multiplier start, waits for done, captures the product and returns it to the winner with a one-cycle valid pulse.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 16, operand/product width, signed two's complement
TIMEOUT, 64, WAIT-state cycle limit (used only with MUL_ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  request level per requester
req_mlr  input  NREQ*DW  multiplier operands; slot i at [i*DW +: DW]
req_mld  input  NREQ*DW  multiplicand operands; slot i at [i*DW +: DW]
gnt  output  NREQ  one-hot, one-cycle grant pulse
rsp_valid  output  NREQ  one-hot, one-cycle result pulse
rsp_prod  output  DW  product, valid with rsp_valid
rsp_err  output  1  timeout flag, valid with rsp_valid
busy  output  1  high in any state other than IDLE
mul_start  output  1  start pulse to the multiplier
mul_mlr  output  DW  operand to the multiplier
mul_mld  output  DW  operand to the multiplier
mul_done  input  1  multiplier completion level
mul_prod  input  DW  multiplier product

Behaviour:
- Reset (async, rst=1): state=IDLE; rr_ptr=0. All outputs are 0: gnt, rsp_valid, rsp_prod, rsp_err, busy, mul_start, mul_mlr, mul_mld. Timeout counter=0.
- Reset mid-transaction aborts immediately. No rsp_valid is issued, and the requester must re-request.
- IDLE: if req!=0, choose the winner by searching req upward from rr_ptr, wrapping at NREQ-1 to 0.
  - Latch the winner's req_mlr/req_mld into mul_mlr/mul_mld.
  - Register gnt[winner]=1 for exactly 1 cycle, in the ISSUE cycle.
  - Next state is ISSUE.
- ISSUE: mul_start=1 for one cycle; next state is WAIT. mul_done is ignored in this cycle.
- WAIT: mul_start=0. mul_mlr/mul_mld stay stable from ISSUE through RESP.
  - The first cycle with mul_done=1 captures mul_prod into rsp_prod; next state is RESP.
- RESP: rsp_valid[winner]=1 for one cycle, rsp_err as computed; rr_ptr=(winner+1) mod NREQ; next state is IDLE.
- Output timing: rsp_prod holds its value until the next capture. gnt/rsp_valid are 0 outside their single cycles.
- Latency with req seen in IDLE at cycle t:
  - gnt at t+1, mul_start at t+1.
  - Earliest capture at t+2, rsp_valid at t+3.
  - Earliest re-arbitration in IDLE at t+4.
- Request rule: a grant consumes the request.
  - The requester must drop req by the cycle after gnt.
  - A req still high when the FSM next reaches IDLE is treated as a new request.
- Fairness: a requester that keeps req high is served at least once every NREQ transactions.
- Simultaneous requests: the lowest index at or above rr_ptr wins. A new req arriving while busy waits for IDLE.
- mul_done outside WAIT is ignored, with no state change.
- Product width is DW; no widening or saturation. The multiplier's truncation is passed through unchanged.
- busy = (state != IDLE).

Optional Feature:
- Macro MUL_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without mul_done: rsp_prod=0, rsp_err=1, go to RESP. The normal rsp_valid pulse and pointer advance follow.
  - A mul_done arriving later is ignored.
- Undefined: no counter; WAIT can last indefinitely; rsp_err is tied to 0.

Test Plan:
- Reset then a single request: req=4'b0001, mlr=3, mld=5, done returned 2 cycles after start -> gnt[0] 1 cycle after req, mul_start 1 cycle, rsp_valid=4'b0001 with rsp_prod=15, busy low after RESP.
- All four requesting continuously, operands i*2 and 7 -> grant order 0,1,2,3,0 and products 0,14,28,42,0, each rsp_valid one-hot.
- rr_ptr=2 after serving 1, req=4'b1011 -> grant to 3, then 0, then 1.
- Signed operands mlr=-4, mld=6 -> rsp_prod=-24 (16'hFFE8). mul_done pulsed high during IDLE beforehand -> ignored, no rsp_valid.
- rst asserted for 1 cycle during WAIT -> all outputs 0 immediately; no rsp_valid; a fresh req after release is served normally.
- With MUL_ARB_TIMEOUT_EN, TIMEOUT=64, mul_done held low -> rsp_valid 64 WAIT cycles after entry with rsp_err=1, rsp_prod=0. A late mul_done is ignored.
